// File: rtl/fmul_seq_ctrl.sv
// Sequential 8x8 multiplier controller (MUL/MULS/MULSU/FMUL/FMULS/FMULSU), one multiplier bit per clock.
// Optional macro FMUL_SEQ_CTRL_FLAGS_EN enables the carry/zero flags; otherwise o_c and o_z stay 0.
module fmul_seq_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [2:0] i_op,
  input  logic [7:0] i_rd,
  input  logic [7:0] i_rr,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [7:0] o_r1,
  output logic [7:0] o_r0,
  output logic       o_c,
  output logic       o_z
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [15:0] acc;
  logic [2:0]  cnt;
  logic        rr_sgn_q;
  logic        frac_q;

  logic        legal;
  logic        rd_sgn;
  logic        rr_sgn;
  logic        frac;
  logic [15:0] addend;
  logic [15:0] acc_next;
  logic [15:0] res;
  logic        c_fin;
  logic        z_fin;
  logic        z_ill;

  always_comb begin
    legal  = 1'b1;
    rd_sgn = 1'b0;
    rr_sgn = 1'b0;
    frac   = 1'b0;
    case (i_op)
      3'b000: ;
      3'b001: begin rd_sgn = 1'b1; rr_sgn = 1'b1; end
      3'b010: rd_sgn = 1'b1;
      3'b011: frac = 1'b1;
      3'b100: begin rd_sgn = 1'b1; rr_sgn = 1'b1; frac = 1'b1; end
      3'b101: begin rd_sgn = 1'b1; frac = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // A signed multiplier's bit 7 carries weight -128, so the final step subtracts.
  always_comb begin
    addend   = mplier[0] ? mcand : '0;
    acc_next = (cnt == 3'd7 && rr_sgn_q) ? acc - addend : acc + addend;
    res      = frac_q ? {acc_next[14:0], 1'b0} : acc_next;
`ifdef FMUL_SEQ_CTRL_FLAGS_EN
    c_fin = acc_next[15];
    z_fin = (res == '0);
    z_ill = 1'b1;
`else
    c_fin = 1'b0;
    z_fin = 1'b0;
    z_ill = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      rr_sgn_q <= 1'b0;
      frac_q   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_r1     <= '0;
      o_r0     <= '0;
      o_c      <= 1'b0;
      o_z      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= rd_sgn ? {{8{i_rd[7]}}, i_rd} : {8'h00, i_rd};
            mplier   <= i_rr;
            rr_sgn_q <= rr_sgn;
            frac_q   <= frac;
            if (legal) begin
              state  <= CALC;
              o_busy <= 1'b1;
              o_done <= 1'b0;
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
              o_err  <= 1'b1;
              o_r1   <= '0;
              o_r0   <= '0;
              o_c    <= 1'b0;
              o_z    <= z_ill;
            end
          end else begin
            state  <= IDLE;
            o_done <= 1'b0;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_err  <= 1'b0;
            o_r1   <= res[15:8];
            o_r0   <= res[7:0];
            o_c    <= c_fin;
            o_z    <= z_fin;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_seq_ctrl.sv
// Self-checking bench for fmul_seq_ctrl: directed cases plus randomized ops against an arithmetic model.
// Flag expectations follow FMUL_SEQ_CTRL_FLAGS_EN the same way the design build does.
module tb_fmul_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_start = 1'b0;
  logic [2:0] i_op = '0;
  logic [7:0] i_rd = '0;
  logic [7:0] i_rr = '0;
  logic       o_busy, o_done, o_err, o_c, o_z;
  logic [7:0] o_r1, o_r0;

  int tests = 0;
  int fails = 0;

  fmul_seq_ctrl dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .i_op   (i_op),
    .i_rd   (i_rd),
    .i_rr   (i_rr),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_err  (o_err),
    .o_r1   (o_r1),
    .o_r0   (o_r0),
    .o_c    (o_c),
    .o_z    (o_z)
  );

  always #5 i_clk = ~i_clk;

  // Reference: plain integer multiplication with the operands interpreted per op.
  function automatic void model(input logic [2:0] op, input logic [7:0] rd, input logic [7:0] rr,
                                output logic [15:0] r, output logic c, output logic z, output logic err);
    int a, b, p;
    logic [15:0] p16;
    a = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5) ? int'($signed(rd)) : int'(rd);
    b = (op == 3'd1 || op == 3'd4) ? int'($signed(rr)) : int'(rr);
    p = a * b;
    p16 = p[15:0];
    if (op >= 3'd6) begin
      r = 16'h0000; c = 1'b0; z = 1'b1; err = 1'b1;
    end else begin
      r = (op >= 3'd3) ? {p16[14:0], 1'b0} : p16;
      c = p16[15];
      z = (r == 16'h0000);
      err = 1'b0;
    end
`ifndef FMUL_SEQ_CTRL_FLAGS_EN
    c = 1'b0;
    z = 1'b0;
`endif
  endfunction

  // Issues one op, scrambles operands after acceptance, and records what the DUT reports.
  task automatic do_op(input logic [2:0] op, input logic [7:0] rd, input logic [7:0] rr,
                       output int busy_n, output int done_at, output logic [15:0] r,
                       output logic c, output logic z, output logic err, output logic done_after);
    @(negedge i_clk);
    i_start = 1'b1; i_op = op; i_rd = rd; i_rr = rr;
    @(posedge i_clk);
    #1;
    i_start = 1'b0; i_op = 3'($urandom); i_rd = 8'($urandom); i_rr = 8'($urandom);
    busy_n = 0; done_at = 0; r = 16'hxxxx; c = 1'bx; z = 1'bx; err = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (o_busy) busy_n++;
      if (o_done) begin
        done_at = k; r = {o_r1, o_r0}; c = o_c; z = o_z; err = o_err;
        break;
      end
    end
    @(negedge i_clk);
    done_after = o_done;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    tests++;
    if ({o_busy, o_done, o_err, o_r1, o_r0, o_c, o_z} !== 21'd0) begin
      fails++;
      $display("FAIL reset_outputs got=%h want=0", {o_busy, o_done, o_err, o_r1, o_r0, o_c, o_z});
    end
    i_rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [2:0]  ops [6] = '{3'd4, 3'd0, 3'd2, 3'd0, 3'd1, 3'd4};
    logic [7:0]  rds [6] = '{8'h40, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'h80};
    logic [7:0]  rrs [6] = '{8'h40, 8'hFF, 8'h02, 8'h37, 8'h80, 8'h80};
    logic [15:0] exp_r [6] = '{16'h2000, 16'hFE01, 16'hFFFE, 16'h0000, 16'h4000, 16'h8000};
    logic        exp_c [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        exp_z [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int busy_n, done_at;
    logic [15:0] r;
    logic c, z, err, done_after, ec, ez;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], rds[i], rrs[i], busy_n, done_at, r, c, z, err, done_after);
`ifdef FMUL_SEQ_CTRL_FLAGS_EN
      ec = exp_c[i]; ez = exp_z[i];
`else
      ec = 1'b0; ez = 1'b0;
`endif
      tests++;
      if (r !== exp_r[i]) begin fails++; $display("FAIL dir%0d_result got=%h want=%h", i, r, exp_r[i]); end
      tests++;
      if (c !== ec || z !== ez) begin fails++; $display("FAIL dir%0d_flags got c=%b z=%b want c=%b z=%b", i, c, z, ec, ez); end
      tests++;
      if (busy_n !== 8 || done_at !== 9) begin fails++; $display("FAIL dir%0d_timing got busy=%0d done_at=%0d want 8/9", i, busy_n, done_at); end
      tests++;
      if (err !== 1'b0 || done_after !== 1'b0) begin fails++; $display("FAIL dir%0d_err_pulse got err=%b done_after=%b want 0/0", i, err, done_after); end
    end
  endtask

  task automatic test_illegal;
    int busy_n, done_at;
    logic [15:0] r;
    logic c, z, err, done_after, ez;
`ifdef FMUL_SEQ_CTRL_FLAGS_EN
    ez = 1'b1;
`else
    ez = 1'b0;
`endif
    do_op(3'b110, 8'h5A, 8'hA5, busy_n, done_at, r, c, z, err, done_after);
    tests++;
    if (busy_n !== 0 || done_at !== 1 || done_after !== 1'b0) begin
      fails++; $display("FAIL illegal_timing got busy=%0d done_at=%0d after=%b want 0/1/0", busy_n, done_at, done_after);
    end
    tests++;
    if (err !== 1'b1 || r !== 16'h0000 || c !== 1'b0 || z !== ez) begin
      fails++; $display("FAIL illegal_result got err=%b r=%h c=%b z=%b want err=1 r=0000 c=0 z=%b", err, r, c, z, ez);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ea, eb, r;
    logic c, z, err;
    int busy_n, got;
    model(3'd0, 8'hC3, 8'h5D, ea, c, z, err);
    model(3'd1, 8'h9E, 8'h27, eb, c, z, err);
    @(negedge i_clk);
    i_start = 1'b1; i_op = 3'd0; i_rd = 8'hC3; i_rr = 8'h5D;
    @(posedge i_clk);
    #1;
    i_op = 3'd1; i_rd = 8'h9E; i_rr = 8'h27;
    busy_n = 0;
    repeat (8) begin @(negedge i_clk); if (o_busy && !o_done) busy_n++; end
    @(negedge i_clk);
    r = {o_r1, o_r0};
    tests++;
    if (busy_n !== 8 || o_done !== 1'b1) begin fails++; $display("FAIL b2b_first_timing got busy=%0d done=%b want 8/1", busy_n, o_done); end
    tests++;
    if (r !== ea) begin fails++; $display("FAIL b2b_first_result got=%h want=%h", r, ea); end
    @(negedge i_clk);
    tests++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin fails++; $display("FAIL b2b_no_idle got busy=%b done=%b want 1/0", o_busy, o_done); end
    i_start = 1'b0;
    got = 0;
    for (int k = 2; k <= 20; k++) begin
      @(negedge i_clk);
      if (o_done) begin got = k; break; end
    end
    r = {o_r1, o_r0};
    tests++;
    if (got !== 9 || r !== eb) begin fails++; $display("FAIL b2b_second got done_at=%0d r=%h want 9/%h", got, r, eb); end
  endtask

  task automatic test_reset_abort;
    int busy_n, done_at, seen;
    logic [15:0] r;
    logic c, z, err, done_after;
    @(negedge i_clk);
    i_start = 1'b1; i_op = 3'd0; i_rd = 8'hB7; i_rr = 8'h6D;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    tests++;
    if ({o_busy, o_done, o_err, o_r1, o_r0, o_c, o_z} !== 21'd0) begin
      fails++; $display("FAIL abort_outputs got=%h want=0", {o_busy, o_done, o_err, o_r1, o_r0, o_c, o_z});
    end
    @(negedge i_clk);
    tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin fails++; $display("FAIL abort_start_ignored got busy=%b done=%b want 0/0", o_busy, o_done); end
    i_rst = 1'b0; i_start = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge i_clk); if (o_done || o_busy) seen++; end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL abort_no_done got activity=%0d want=0", seen); end
    do_op(3'd0, 8'h03, 8'h05, busy_n, done_at, r, c, z, err, done_after);
    tests++;
    if (r !== 16'h000F || done_at !== 9) begin fails++; $display("FAIL abort_fresh_mul got r=%h done_at=%0d want 000f/9", r, done_at); end
  endtask

  task automatic test_random;
    int busy_n, done_at;
    logic [2:0] op;
    logic [7:0] rd, rr;
    logic [15:0] r, er;
    logic c, z, err, done_after, ec, ez, eerr;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom); rd = 8'($urandom); rr = 8'($urandom);
      model(op, rd, rr, er, ec, ez, eerr);
      do_op(op, rd, rr, busy_n, done_at, r, c, z, err, done_after);
      tests++;
      if (r !== er || c !== ec || z !== ez || err !== eerr) begin
        fails++;
        $display("FAIL rnd%0d op=%0d rd=%h rr=%h got r=%h c=%b z=%b err=%b want r=%h c=%b z=%b err=%b",
                 i, op, rd, rr, r, c, z, err, er, ec, ez, eerr);
      end
      tests++;
      if (busy_n !== (eerr ? 0 : 8) || done_at !== (eerr ? 1 : 9) || done_after !== 1'b0) begin
        fails++;
        $display("FAIL rnd%0d_timing op=%0d got busy=%0d done_at=%0d after=%b", i, op, busy_n, done_at, done_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
